// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, error causes, command bytes
// and the host-to-device frame builder.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SEND      = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5,
      ST_DONE      = 3'd6,
      ST_ERR       = 3'd7
   } ps2_state_e;

   localparam logic [1:0] PS2_ERR_NONE     = 2'd0;
   localparam logic [1:0] PS2_ERR_START_TO = 2'd1;
   localparam logic [1:0] PS2_ERR_XFER_TO  = 2'd2;
   localparam logic [1:0] PS2_ERR_NO_ACK   = 2'd3;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

   // Bits in line order from index 0: data LSB first, odd parity, stop.
   function automatic logic [9:0] ps2_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-flop synchronizer, stability filter and falling-edge pulse.
// Filtered output lags the pin by 2 + FILT_CYC cycles; fall_o is registered, no backpressure.
module ps2_line_sync #(
   parameter int FILT_CYC = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic filt_o,
   output logic fall_o
);

   localparam int CW = (FILT_CYC < 1) ? 1 : $clog2(FILT_CYC + 1);

   logic [1:0]    sync_q;
   logic          filt_q, filt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fall_q;

   // The counter only runs while the synchronized level disagrees with the filtered one,
   // so it tops out at FILT_CYC-1 and can never wrap.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q[1] != filt_q) begin
         if (cnt_q == CW'(FILT_CYC - 1)) begin
            filt_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         cnt_q  <= '0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], line_i};
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
         fall_q <= filt_q & ~filt_d;
      end
   end

   assign filt_o = filt_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out 11-bit frame, check ack.
// First bit changes >= INHIBIT_CYC+1 cycles after accept; tx_ready low while busy, no queueing.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ       = 50000000,
   parameter int INHIBIT_CYC  = 6000,
   parameter int START_TO_CYC = 750000,
   parameter int XFER_TO_CYC  = 100000,
   parameter int FILT_CYC     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_drv_low,
   output logic       ps2_data_drv_low,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic [1:0] err_code
);

   localparam int unused_clk_hz = CLK_HZ;
   localparam int TMAX_A = (INHIBIT_CYC > START_TO_CYC) ? INHIBIT_CYC : START_TO_CYC;
   localparam int TMAX   = (TMAX_A > XFER_TO_CYC) ? TMAX_A : XFER_TO_CYC;
   localparam int TW     = $clog2(TMAX + 1);

   ps2_state_e    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [9:0]    shift_q, shift_d;
   logic [3:0]    idx_q, idx_d;
   logic [1:0]    err_q, err_d;

   logic clk_f, clk_fall, data_f;
   logic unused_data_fall;
   logic xfer_exp;

   ps2_line_sync #(.FILT_CYC(FILT_CYC)) u_clk_sync (
      .clk    (clk),
      .rst_n  (reset),
      .line_i (ps2_clk_in),
      .filt_o (clk_f),
      .fall_o (clk_fall)
   );

   ps2_line_sync #(.FILT_CYC(FILT_CYC)) u_data_sync (
      .clk    (clk),
      .rst_n  (reset),
      .line_i (ps2_data_in),
      .filt_o (data_f),
      .fall_o (unused_data_fall)
   );

   assign xfer_exp = (timer_q == TW'(XFER_TO_CYC - 1));

   always_comb begin
      state_d          = state_q;
      timer_d          = (timer_q == TW'(TMAX)) ? timer_q : timer_q + TW'(1);
      shift_d          = shift_q;
      idx_d            = idx_q;
      err_d            = err_q;
      ps2_clk_drv_low  = 1'b0;
      ps2_data_drv_low = 1'b0;
      tx_done          = 1'b0;
      tx_error         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (tx_valid) begin
               shift_d = ps2_frame(tx_data);
               idx_d   = '0;
               state_d = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            // Device clock edges are ignored here: the host owns the bus while inhibiting.
            ps2_clk_drv_low = 1'b1;
            if (timer_q == TW'(INHIBIT_CYC - 1)) begin
               ps2_data_drv_low = 1'b1;
               timer_d          = '0;
               state_d          = ST_REQ;
            end
         end
         ST_REQ: begin
            ps2_data_drv_low = 1'b1;
            if (timer_q == TW'(START_TO_CYC - 1)) begin
               err_d   = PS2_ERR_START_TO;
               state_d = ST_ERR;
            end else if (clk_fall) begin
               idx_d   = '0;
               timer_d = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            ps2_data_drv_low = ~shift_q[idx_q];
            if (xfer_exp) begin
               err_d   = PS2_ERR_XFER_TO;
               state_d = ST_ERR;
            end else if (clk_fall) begin
               if (idx_q == 4'd9) begin
                  state_d = ST_ACK;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ST_ACK: begin
            if (xfer_exp) begin
               err_d   = PS2_ERR_XFER_TO;
               state_d = ST_ERR;
            end else if (clk_fall) begin
               if (!data_f) begin
                  state_d = ST_WAIT_IDLE;
               end else begin
                  err_d   = PS2_ERR_NO_ACK;
                  state_d = ST_ERR;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (xfer_exp) begin
               err_d   = PS2_ERR_XFER_TO;
               state_d = ST_ERR;
            end else if (clk_f && data_f) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            tx_done = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ERR: begin
            tx_error = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         shift_q <= '0;
         idx_q   <= '0;
         err_q   <= PS2_ERR_NONE;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign tx_ready = (state_q == ST_IDLE);
   assign busy     = ~tx_ready;
   assign err_code = err_q;

endmodule
